// File: rtl/serial_rx_control.sv
// Asynchronous serial receiver control for an 8051-style UART (modes 1/2/3).
// 16x oversampling with 7/8/9 majority vote, multiprocessor filter, and RI/SBUF load strobes.
module serial_rx_control (
  input  logic       serial_clock_i,
  input  logic       serial_reset_i_b,
  input  logic       serial_br_i,
  input  logic       serial_scon4_ren_i,
  input  logic       serial_scon7_sm0_i,
  input  logic       serial_scon5_sm2_i,
  input  logic       serial_scon0_ri_i,
  input  logic       serial_rxd_data_i,
  output logic [7:0] serial_rx_sbuf_o,
  output logic       serial_rx_rb8_o,
  output logic       serial_rx_load_o,
  output logic       serial_rx_set_ri_o,
  output logic       serial_rx_busy_o,
  output logic       serial_rx_frame_err_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, BIT9, STOP} state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t      state;
  logic        rxd_p0;
  logic        rxs;
  logic        rxs_tick;
  logic [3:0]  smp_cnt;
  logic [2:0]  bit_cnt;
  logic        sm0_l;
  logic        sm2_l;
  logic [7:0]  shift_p1;
  logic        s7_p1;
  logic        s8_p1;
  logic        bit9_p1;
  logic        maj;
  logic        rb8_cand;
  logic        accept;

  assign maj      = majority3(s7_p1, s8_p1, rxs);
  assign rb8_cand = sm0_l ? bit9_p1 : maj;
  assign accept   = !serial_scon0_ri_i && (!sm2_l || rb8_cand);

  // Control: synchronizer, FSM, counters and registered strobes.
  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      rxd_p0                <= 1'b1;
      rxs                   <= 1'b1;
      rxs_tick              <= 1'b1;
      state                 <= IDLE;
      smp_cnt               <= 4'd0;
      bit_cnt               <= 3'd0;
      sm0_l                 <= 1'b0;
      sm2_l                 <= 1'b0;
      serial_rx_sbuf_o      <= 8'h00;
      serial_rx_rb8_o       <= 1'b0;
      serial_rx_load_o      <= 1'b0;
      serial_rx_set_ri_o    <= 1'b0;
      serial_rx_busy_o      <= 1'b0;
      serial_rx_frame_err_o <= 1'b0;
    end else begin
      rxd_p0                <= serial_rxd_data_i;
      rxs                   <= rxd_p0;
      serial_rx_load_o      <= 1'b0;
      serial_rx_set_ri_o    <= 1'b0;
      serial_rx_frame_err_o <= 1'b0;
      if (serial_br_i) rxs_tick <= rxs;

      if (state != IDLE && !serial_scon4_ren_i) begin
        state            <= IDLE;
        serial_rx_busy_o <= 1'b0;
        smp_cnt          <= 4'd0;
        bit_cnt          <= 3'd0;
      end else if (serial_br_i) begin
        case (state)
          IDLE: begin
            if (serial_scon4_ren_i && rxs_tick && !rxs) begin
              state            <= START;
              serial_rx_busy_o <= 1'b1;
              smp_cnt          <= 4'd0;
              bit_cnt          <= 3'd0;
              sm0_l            <= serial_scon7_sm0_i;
              sm2_l            <= serial_scon5_sm2_i;
            end
          end
          START: begin
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_cnt == 4'd9 && maj) begin
              state            <= IDLE;
              serial_rx_busy_o <= 1'b0;
              smp_cnt          <= 4'd0;
            end else if (smp_cnt == 4'd15) begin
              state <= DATA;
            end
          end
          DATA: begin
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_cnt == 4'd15) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= sm0_l ? BIT9 : STOP;
            end
          end
          BIT9: begin
            smp_cnt <= smp_cnt + 4'd1;
            if (smp_cnt == 4'd15) state <= STOP;
          end
          STOP: begin
            smp_cnt <= smp_cnt + 4'd1;
            // Decide at mid stop bit so a back-to-back start edge is not missed.
            if (smp_cnt == 4'd9) begin
              state                 <= IDLE;
              serial_rx_busy_o      <= 1'b0;
              smp_cnt               <= 4'd0;
              serial_rx_frame_err_o <= !maj;
              serial_rx_load_o      <= accept;
              serial_rx_set_ri_o    <= accept;
              if (accept) begin
                serial_rx_sbuf_o <= shift_p1;
                serial_rx_rb8_o  <= rb8_cand;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Datapath: vote samples and bit assembly.
  always_ff @(posedge serial_clock_i) begin
    if (serial_br_i && state != IDLE) begin
      if (smp_cnt == 4'd7) s7_p1 <= rxs;
      if (smp_cnt == 4'd8) s8_p1 <= rxs;
      if (smp_cnt == 4'd9) begin
        if (state == DATA) shift_p1 <= {maj, shift_p1[7:1]};
        if (state == BIT9) bit9_p1  <= maj;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_control.sv
// Self-checking bench for serial_rx_control: directed scenarios plus randomized frames vs. a frame-level model.
module tb_serial_rx_control;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       br = 1'b0;
  logic       ren = 1'b0;
  logic       sm0 = 1'b0;
  logic       sm2 = 1'b0;
  logic       ri = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] sbuf;
  logic       rb8, load, set_ri, busy, ferr;

  int checks = 0;
  int failures = 0;
  int c_load = 0, c_ri = 0, c_ferr = 0, c_ne = 0, c_fl = 0, c_bad = 0;
  logic [7:0] prev_sbuf;
  logic [7:0] exp_sbuf = 8'h00;
  logic       exp_rb8 = 1'b0;

  serial_rx_control dut (
    .serial_clock_i       (clk),
    .serial_reset_i_b     (rst_n),
    .serial_br_i          (br),
    .serial_scon4_ren_i   (ren),
    .serial_scon7_sm0_i   (sm0),
    .serial_scon5_sm2_i   (sm2),
    .serial_scon0_ri_i    (ri),
    .serial_rxd_data_i    (rxd),
    .serial_rx_sbuf_o     (sbuf),
    .serial_rx_rb8_o      (rb8),
    .serial_rx_load_o     (load),
    .serial_rx_set_ri_o   (set_ri),
    .serial_rx_busy_o     (busy),
    .serial_rx_frame_err_o(ferr)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    forever begin
      for (int i = 0; i < DIV; i++) begin
        @(negedge clk);
        br = (i == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) prev_sbuf = sbuf;
    else begin
      if (load === 1'b1) c_load++;
      if (set_ri === 1'b1) c_ri++;
      if (ferr === 1'b1) c_ferr++;
      if (load !== set_ri) c_ne++;
      if (ferr === 1'b1 && load === 1'b1) c_fl++;
      if (sbuf !== prev_sbuf && load !== 1'b1) c_bad++;
      prev_sbuf = sbuf;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic nine, input logic b9, input logic stop,
                            input logic flip, input int gap,
                            output int n_load, output int n_ri, output int n_ferr, output int n_ne,
                            output int n_fl, output int n_bad, output logic busy_mid);
    int l0, r0, f0, e0, fl0, b0;
    l0 = c_load; r0 = c_ri; f0 = c_ferr; e0 = c_ne; fl0 = c_fl; b0 = c_bad;
    drive_bit(1'b0);
    if (flip) begin
      sm0 = ~sm0;
      sm2 = ~sm2;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (nine) drive_bit(b9);
    rxd = stop;
    wait_ticks(12);
    busy_mid = busy;
    wait_ticks(4);
    rxd = 1'b1;
    wait_ticks(16 * gap);
    n_load = c_load - l0; n_ri = c_ri - r0; n_ferr = c_ferr - f0;
    n_ne = c_ne - e0; n_fl = c_fl - fl0; n_bad = c_bad - b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ren = 1'b0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sbuf !== 8'h00) begin failures++; $display("FAIL reset_sbuf got=%h exp=00", sbuf); end
    checks++; if ({busy, rb8, load, set_ri, ferr} !== 5'b0) begin failures++;
      $display("FAIL reset_flags got=%b exp=00000", {busy, rb8, load, set_ri, ferr}); end
    #2 rst_n = 1'b1;
    exp_sbuf = 8'h00; exp_rb8 = 1'b0;
    ren = 1'b1;
    wait_ticks(20);
  endtask

  task automatic test_basic;
    int nl, nr, nf, ne, nfl, nb; logic bm;
    sm0 = 0; sm2 = 0; ri = 0; ren = 1;
    send_frame(8'hA5, 0, 0, 1, 0, 1, nl, nr, nf, ne, nfl, nb, bm);
    exp_sbuf = 8'hA5; exp_rb8 = 1'b1;
    checks++; if (nl != 1) begin failures++; $display("FAIL basic_load got=%0d exp=1", nl); end
    checks++; if (nr != 1) begin failures++; $display("FAIL basic_set_ri got=%0d exp=1", nr); end
    checks++; if (ne != 0) begin failures++; $display("FAIL basic_coincide got=%0d exp=0", ne); end
    checks++; if (nf != 0) begin failures++; $display("FAIL basic_ferr got=%0d exp=0", nf); end
    checks++; if (bm !== 1'b0) begin failures++; $display("FAIL basic_early_idle busy=%b exp=0", bm); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL basic_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
    checks++; if (rb8 !== exp_rb8) begin failures++; $display("FAIL basic_rb8 got=%b exp=%b", rb8, exp_rb8); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
  endtask

  task automatic test_false_start;
    int l0, f0, r0;
    l0 = c_load; f0 = c_ferr; r0 = c_ri;
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    wait_ticks(2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL false_start_detect busy=%b exp=1", busy); end
    wait_ticks(20);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL false_start_idle busy=%b exp=0", busy); end
    checks++; if ((c_load - l0) + (c_ferr - f0) + (c_ri - r0) != 0) begin failures++;
      $display("FAIL false_start_strobes got=%0d exp=0", (c_load - l0) + (c_ferr - f0) + (c_ri - r0)); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL false_start_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
  endtask

  task automatic test_ri_block;
    int nl, nr, nf, ne, nfl, nb; logic bm;
    sm0 = 0; sm2 = 0; ri = 1;
    send_frame(8'h5A, 0, 0, 1, 0, 1, nl, nr, nf, ne, nfl, nb, bm);
    ri = 0;
    checks++; if (nl + nr != 0) begin failures++; $display("FAIL ri_block_strobes got=%0d exp=0", nl + nr); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL ri_block_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
  endtask

  task automatic test_multiproc;
    int nl, nr, nf, ne, nfl, nb; logic bm;
    sm0 = 1; sm2 = 1; ri = 0;
    send_frame(8'h3C, 1, 0, 1, 0, 1, nl, nr, nf, ne, nfl, nb, bm);
    checks++; if (nl != 0) begin failures++; $display("FAIL mp_reject_load got=%0d exp=0", nl); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL mp_reject_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
    send_frame(8'h3C, 1, 1, 1, 0, 1, nl, nr, nf, ne, nfl, nb, bm);
    exp_sbuf = 8'h3C; exp_rb8 = 1'b1;
    checks++; if (nl != 1 || nr != 1) begin failures++; $display("FAIL mp_accept_strobes got=%0d/%0d exp=1/1", nl, nr); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL mp_accept_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
    checks++; if (rb8 !== exp_rb8) begin failures++; $display("FAIL mp_accept_rb8 got=%b exp=%b", rb8, exp_rb8); end
    sm0 = 0; sm2 = 0;
  endtask

  task automatic test_frame_err;
    int nl, nr, nf, ne, nfl, nb; logic bm;
    sm0 = 0; sm2 = 0; ri = 0;
    send_frame(8'h96, 0, 0, 0, 0, 1, nl, nr, nf, ne, nfl, nb, bm);
    exp_sbuf = 8'h96; exp_rb8 = 1'b0;
    checks++; if (nl != 1) begin failures++; $display("FAIL ferr_load got=%0d exp=1", nl); end
    checks++; if (nf != 1) begin failures++; $display("FAIL ferr_pulse got=%0d exp=1", nf); end
    checks++; if (nfl != 1) begin failures++; $display("FAIL ferr_with_load got=%0d exp=1", nfl); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL ferr_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
    checks++; if (rb8 !== exp_rb8) begin failures++; $display("FAIL ferr_rb8 got=%b exp=%b", rb8, exp_rb8); end
  endtask

  task automatic test_abort_ren;
    int l0, f0, r0;
    logic [7:0] d;
    d = 8'hC6;
    l0 = c_load; f0 = c_ferr; r0 = c_ri;
    ren = 1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rxd = d[3];
    wait_ticks(8);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got=%b exp=1", busy); end
    ren = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy_after got=%b exp=0", busy); end
    wait_ticks(8);
    for (int i = 4; i < 8; i++) drive_bit(d[i]);
    drive_bit(1'b1);
    wait_ticks(8);
    ren = 1;
    wait_ticks(4);
    checks++; if ((c_load - l0) + (c_ferr - f0) + (c_ri - r0) != 0) begin failures++;
      $display("FAIL abort_strobes got=%0d exp=0", (c_load - l0) + (c_ferr - f0) + (c_ri - r0)); end
    checks++; if (sbuf !== exp_sbuf) begin failures++; $display("FAIL abort_sbuf got=%h exp=%h", sbuf, exp_sbuf); end
  endtask

  task automatic test_reset_midframe;
    int l0, f0, r0;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rxd = 1'b1;
    wait_ticks(5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_busy_before got=%b exp=1", busy); end
    #2 rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    checks++; if ({busy, rb8, load, set_ri, ferr} !== 5'b0) begin failures++;
      $display("FAIL rst_mid_flags got=%b exp=00000", {busy, rb8, load, set_ri, ferr}); end
    checks++; if (sbuf !== 8'h00) begin failures++; $display("FAIL rst_mid_sbuf got=%h exp=00", sbuf); end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    exp_sbuf = 8'h00; exp_rb8 = 1'b0;
    l0 = c_load; f0 = c_ferr; r0 = c_ri;
    wait_ticks(40);
    checks++; if ((c_load - l0) + (c_ferr - f0) + (c_ri - r0) != 0 || busy !== 1'b0) begin failures++;
      $display("FAIL rst_mid_after strobes=%0d busy=%b exp=0/0", (c_load - l0) + (c_ferr - f0) + (c_ri - r0), busy); end
  endtask

  task automatic test_back_to_back;
    int nl, nr, nf, ne, nfl, nb; logic bm;
    sm0 = 0; sm2 = 0; ri = 0;
    send_frame(8'h11, 0, 0, 1, 0, 0, nl, nr, nf, ne, nfl, nb, bm);
    checks++; if (nl != 1 || sbuf !== 8'h11) begin failures++; $display("FAIL b2b_first load=%0d sbuf=%h exp=1/11", nl, sbuf); end
    send_frame(8'hEE, 0, 0, 1, 0, 1, nl, nr, nf, ne, nfl, nb, bm);
    exp_sbuf = 8'hEE; exp_rb8 = 1'b1;
    checks++; if (nl != 1 || sbuf !== 8'hEE) begin failures++; $display("FAIL b2b_second load=%0d sbuf=%h exp=1/ee", nl, sbuf); end
  endtask

  task automatic test_random;
    int nl, nr, nf, ne, nfl, nb; logic bm;
    logic [7:0] d; logic nine, b9, stop, rix, sm2x, flip, rb8c, acc; int gap;
    for (int k = 0; k < 16; k++) begin
      d = 8'($urandom); nine = 1'($urandom_range(0, 1)); b9 = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0); rix = ($urandom_range(0, 3) == 0);
      sm2x = 1'($urandom_range(0, 1)); flip = ($urandom_range(0, 3) == 0);
      gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      sm0 = nine; sm2 = sm2x; ri = rix;
      rb8c = nine ? b9 : stop;
      acc = !rix && (!sm2x || rb8c);
      send_frame(d, nine, b9, stop, flip, gap, nl, nr, nf, ne, nfl, nb, bm);
      if (acc) begin exp_sbuf = d; exp_rb8 = rb8c; end
      checks++; if (nl != int'(acc) || nr != int'(acc)) begin failures++;
        $display("FAIL rand%0d_strobes load=%0d ri=%0d exp=%0d", k, nl, nr, acc); end
      checks++; if (nf != int'(!stop)) begin failures++; $display("FAIL rand%0d_ferr got=%0d exp=%0d", k, nf, !stop); end
      checks++; if (ne != 0 || nb != 0) begin failures++; $display("FAIL rand%0d_glitch ne=%0d bad=%0d exp=0/0", k, ne, nb); end
      checks++; if (sbuf !== exp_sbuf || rb8 !== exp_rb8) begin failures++;
        $display("FAIL rand%0d_data got=%h/%b exp=%h/%b", k, sbuf, rb8, exp_sbuf, exp_rb8); end
    end
    ri = 0; sm0 = 0; sm2 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_ri_block();
    test_multiproc();
    test_frame_err();
    test_abort_ren();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_rx_control.md
SERIAL_RX_CONTROL -- requirements
Module: serial_rx_control

Interface
REQ-001 The block SHALL have one clock, `serial_clock_i`; reset SHALL be asynchronous and active-low on `serial_reset_i_b`.
REQ-002 The block SHALL have these ports:
- `serial_clock_i`  in  1  system clock.
- `serial_reset_i_b`  in  1  async active-low reset.
- `serial_br_i`  in  1  one-cycle tick at 16x receive baud rate.
- `serial_scon4_ren_i`  in  1  receive enable.
- `serial_scon7_sm0_i`  in  1  0 = 8-bit frame (mode 1), 1 = 9-bit frame (modes 2/3).
- `serial_scon5_sm2_i`  in  1  multiprocessor filter enable.
- `serial_scon0_ri_i`  in  1  current RI flag.
- `serial_rxd_data_i`  in  1  raw RXD pin (P3.0).
- `serial_rx_sbuf_o`  out  8  received data byte.
- `serial_rx_rb8_o`  out  1  received 9th bit or stop bit.
- `serial_rx_load_o`  out  1  one-cycle strobe: `serial_rx_sbuf_o` and `serial_rx_rb8_o` updated.
- `serial_rx_set_ri_o`  out  1  one-cycle request to set SCON.RI.
- `serial_rx_busy_o`  out  1  frame in progress.
- `serial_rx_frame_err_o`  out  1  one-cycle strobe: stop bit sampled 0.

Function
REQ-003 RXD SHALL pass a 2-flop synchronizer; all further logic SHALL use the synchronized value `rxs`.
REQ-004 The FSM SHALL have five states: IDLE, START, DATA, BIT9, STOP.
REQ-005 A 4-bit sample counter SHALL increment on every `serial_br_i` tick outside IDLE, wrapping 15->0; it SHALL be cleared on entry to START.
REQ-006 Each bit value SHALL be the majority of `rxs` captured on the ticks where the counter equals 7, 8 and 9.
REQ-007 IDLE -> START SHALL occur on a `serial_br_i` tick where `serial_scon4_ren_i` = 1 and `rxs` falls 1->0 against the previous tick's sample.
REQ-008 START: if the majority at counter 9 is 1 (false start), the FSM SHALL return to IDLE with no outputs pulsed; otherwise, at the tick where the counter wraps 15->0, the FSM SHALL go to DATA.
REQ-009 DATA: each majority bit SHALL be shifted in LSB first; a 3-bit bit counter SHALL advance at each counter wrap. After the 8th bit, the FSM SHALL go to BIT9 if `serial_scon7_sm0_i` = 1, else to STOP.
REQ-010 BIT9 SHALL capture the majority bit as the 9th bit and then go to STOP at the counter wrap.
REQ-011 STOP: at the counter-9 tick the FSM SHALL evaluate acceptance and go to IDLE on that same tick, without waiting for the full stop-bit time.
REQ-012 rb8 candidate: the 9th bit in 9-bit mode; the stop bit in 8-bit mode.
REQ-013 Accept condition: `serial_scon0_ri_i` = 0 AND (`serial_scon5_sm2_i` = 0 OR rb8 candidate = 1).
REQ-014 On accept, the cycle after the decision tick, `serial_rx_sbuf_o` and `serial_rx_rb8_o` SHALL update, and `serial_rx_load_o` and `serial_rx_set_ri_o` SHALL each be high for exactly one cycle.
REQ-015 On reject, there SHALL be no strobes, and `serial_rx_sbuf_o` and `serial_rx_rb8_o` SHALL hold.
REQ-016 If the stop bit majority is 0, `serial_rx_frame_err_o` SHALL pulse one cycle, coincident with the decision cycle + 1, whether or not the frame is accepted.
REQ-017 `serial_scon4_ren_i` = 0 in any non-IDLE state SHALL abort to IDLE on the next clock, with no strobes.
REQ-018 `serial_rx_busy_o` SHALL be 1 in every state except IDLE.
REQ-019 The `serial_scon7_sm0_i` and `serial_scon5_sm2_i` values SHALL be latched on IDLE->START; mid-frame changes SHALL NOT affect the current frame.
REQ-020 A falling edge arriving while not IDLE SHALL be ignored.
REQ-021 A new start SHALL be detectable from the first tick after returning to IDLE.

Reset
REQ-022 While `serial_reset_i_b` = 0, the block SHALL force: FSM = IDLE; counters = 0; `serial_rx_sbuf_o` = 8'h00; `serial_rx_rb8_o`, `serial_rx_load_o`, `serial_rx_set_ri_o`, `serial_rx_busy_o`, `serial_rx_frame_err_o` = 0; synchronizer flops = 1.
REQ-023 A reset asserted mid-frame SHALL discard the partial frame, with no strobes after release.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- SM0=0, REN=1, RI=0; frame 0xA5 with stop=1 -> sbuf=0xA5, rb8=1; load and set_ri each one cycle; busy returns to 0.
- Start low for 4 ticks only -> false start; FSM back to IDLE; no strobes; sbuf unchanged.
- RI=1 during an 8-bit frame 0x5A -> no load; sbuf keeps its old value.
- SM0=1, SM2=1: frame 0x3C with bit9=0 -> rejected. Then 0x3C with bit9=1 -> sbuf=0x3C, rb8=1, strobes.
- SM0=0, stop bit=0, RI=0, SM2=0 -> sbuf loaded, rb8=0, frame_err pulse.
- REN cleared in DATA bit 3, or reset asserted mid-frame -> busy=0 next cycle; no strobes; after reset, all outputs 0.
